// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Shared state encodings, default sync header and counter sizing helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        BIT_IDLE      = 3'd0,
        BIT_START     = 3'd1,
        BIT_DATA      = 3'd2,
        BIT_STOP      = 3'd3,
        BIT_WAIT_HIGH = 3'd4
    } bit_state_e;

    typedef enum logic [2:0] {
        BYTE_HUNT0   = 3'd0,
        BYTE_HUNT1   = 3'd1,
        BYTE_LEN     = 3'd2,
        BYTE_PAYLOAD = 3'd3,
        BYTE_CHK     = 3'd4
    } byte_state_e;

    localparam logic [7:0] c_sync0_default = 8'hAA;
    localparam logic [7:0] c_sync1_default = 8'h55;

    // Bits needed to hold the largest payload count a length byte can request.
    function automatic int rem_width(input int data_bits, input int len_mul, input int len_add);
        longint max_v;
        int     w;
        max_v = ((longint'(1) << data_bits) - 1) * longint'(len_mul) + longint'(len_add);
        w     = 1;
        for (int i = 1; i < 48; i++) begin
            if ((longint'(1) << i) <= max_v) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_packet_rx_if.sv
// ============================================================================
// Module : uart_packet_rx_if
// Serial input and packet/strobe outputs of the packet receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_packet_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 stream;
    logic [DATA_BITS-1:0] outstream;
    logic                 infodump;
    logic                 sof;
    logic                 eop;
    logic                 frame_err;
    logic                 sync_err;
    logic                 chk_err;
    logic                 busy;

    modport master (
        input  stream,
        output outstream, infodump, sof, eop, frame_err, sync_err, chk_err, busy
    );

    modport slave (
        output stream,
        input  outstream, infodump, sof, eop, frame_err, sync_err, chk_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_bit_rx.sv
// ============================================================================
// Module : uart_bit_rx
// Two-flop synchroniser and mid-bit sampling character receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_bit_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    input  wire logic                 stream_i,
    output logic      [DATA_BITS-1:0] char_o,
    output logic                      char_stb_o,
    output logic                      frame_err_o
);

    localparam int CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIDX_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0]  c_half_load = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  c_bit_load  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0] c_last_bit  = BIDX_W'(DATA_BITS - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    bit_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIDX_W-1:0]    bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 stb_q, stb_d;
    logic                 ferr_q, ferr_d;

    logic w_rx;
    logic w_expire;

    assign w_rx     = sync2_q;
    assign w_expire = (cnt_q == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= BIT_IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            shreg_q <= '0;
            stb_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= stream_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
            stb_q   <= stb_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        case (state_q)
            BIT_IDLE: begin
                if (!w_rx) begin
                    state_d = BIT_START;
                    cnt_d   = c_half_load;
                end
            end
            BIT_START: begin
                if (!w_expire) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!w_rx) begin
                    state_d = BIT_DATA;
                    cnt_d   = c_bit_load;
                    bidx_d  = '0;
                end else begin
                    state_d = BIT_IDLE;
                end
            end
            BIT_DATA: begin
                if (!w_expire) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // LSB arrives first, so shifting in at the top leaves it at bit 0.
                    shreg_d = {w_rx, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = c_bit_load;
                    if (bidx_q == c_last_bit) begin
                        state_d = BIT_STOP;
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end
            end
            BIT_STOP: begin
                if (!w_expire) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = w_rx ? BIT_IDLE : BIT_WAIT_HIGH;
                end
            end
            BIT_WAIT_HIGH: begin
                if (w_rx) begin
                    state_d = BIT_IDLE;
                end
            end
            default: begin
                state_d = BIT_IDLE;
            end
        endcase
    end

    always_comb begin
        stb_d  = (state_q == BIT_STOP) && w_expire && w_rx;
        ferr_d = (state_q == BIT_STOP) && w_expire && !w_rx;
    end

    assign char_o      = shreg_q;
    assign char_stb_o  = stb_q;
    assign frame_err_o = ferr_q;

endmodule

`default_nettype wire

// File: rtl/uart_packet_rx.sv
// ============================================================================
// Module : uart_packet_rx
// Sync-hunting packet receiver: length, scaled payload count, XOR checksum.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_packet_rx
    import uart_pkg::*;
#(
    parameter int                   CLKS_PER_BIT = 868,
    parameter int                   DATA_BITS    = 8,
    parameter logic [DATA_BITS-1:0] SYNC0        = DATA_BITS'(c_sync0_default),
    parameter logic [DATA_BITS-1:0] SYNC1        = DATA_BITS'(c_sync1_default),
    parameter int                   LEN_MUL      = 2,
    parameter int                   LEN_ADD      = 4,
    parameter bit                   CHK_EN       = 1'b1
) (
    input  wire logic         clock,
    input  wire logic         reset,
    uart_packet_rx_if.master  bus
);

    localparam int REM_W = rem_width(DATA_BITS, LEN_MUL, LEN_ADD);

    logic [DATA_BITS-1:0] w_char;
    logic                 w_char_stb;
    logic                 w_frame_err;

    uart_bit_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS)
    ) u_bit_rx (
        .clock       (clock),
        .reset       (reset),
        .stream_i    (bus.stream),
        .char_o      (w_char),
        .char_stb_o  (w_char_stb),
        .frame_err_o (w_frame_err)
    );

    byte_state_e          state_q, state_d;
    logic [REM_W-1:0]     rem_q, rem_d;
    logic [DATA_BITS-1:0] xsum_q, xsum_d;

    logic [DATA_BITS-1:0] outstream_q;
    logic                 infodump_q, sof_q, eop_q, frame_err_q, sync_err_q, chk_err_q, busy_q;

    logic w_info, w_sof, w_eop, w_sync_err, w_chk_err, w_busy;
    logic [REM_W-1:0] w_len_count;
    logic w_abort;

    assign w_len_count = REM_W'(w_char) * REM_W'(LEN_MUL) + REM_W'(LEN_ADD);
    assign w_abort     = w_frame_err && (state_q != BYTE_HUNT0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= BYTE_HUNT0;
            rem_q   <= '0;
            xsum_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            xsum_q  <= xsum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        xsum_d  = xsum_q;
        if (w_abort) begin
            state_d = BYTE_HUNT0;
        end else if (w_char_stb) begin
            case (state_q)
                BYTE_HUNT0: begin
                    if (w_char == SYNC0) state_d = BYTE_HUNT1;
                end
                BYTE_HUNT1: begin
                    if (w_char == SYNC1)      state_d = BYTE_LEN;
                    else if (w_char != SYNC0) state_d = BYTE_HUNT0;
                end
                BYTE_LEN: begin
                    rem_d  = w_len_count;
                    xsum_d = w_char;
                    if (w_len_count != '0) state_d = BYTE_PAYLOAD;
                    else                   state_d = CHK_EN ? BYTE_CHK : BYTE_HUNT0;
                end
                BYTE_PAYLOAD: begin
                    rem_d  = rem_q - 1'b1;
                    xsum_d = xsum_q ^ w_char;
                    if (rem_q == REM_W'(1)) state_d = CHK_EN ? BYTE_CHK : BYTE_HUNT0;
                end
                BYTE_CHK: begin
                    state_d = BYTE_HUNT0;
                end
                default: begin
                    state_d = BYTE_HUNT0;
                end
            endcase
        end
    end

    always_comb begin
        w_info     = 1'b0;
        w_sof      = 1'b0;
        w_eop      = 1'b0;
        w_sync_err = 1'b0;
        w_chk_err  = 1'b0;
        if (w_char_stb && !w_abort) begin
            case (state_q)
                BYTE_HUNT1: begin
                    w_sync_err = (w_char != SYNC1) && (w_char != SYNC0);
                end
                BYTE_LEN: begin
                    w_info = 1'b1;
                    w_sof  = 1'b1;
                    w_eop  = (w_len_count == '0) && !CHK_EN;
                end
                BYTE_PAYLOAD: begin
                    w_info = 1'b1;
                    w_eop  = (rem_q == REM_W'(1)) && !CHK_EN;
                end
                BYTE_CHK: begin
                    w_info    = 1'b1;
                    w_eop     = 1'b1;
                    w_chk_err = (w_char != xsum_q);
                end
                default: begin
                end
            endcase
        end
        w_busy = (state_d != BYTE_HUNT0);
    end

    // Strobes land one clock after the character strobe, busy on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstream_q <= '0;
            infodump_q  <= 1'b0;
            sof_q       <= 1'b0;
            eop_q       <= 1'b0;
            frame_err_q <= 1'b0;
            sync_err_q  <= 1'b0;
            chk_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (w_info) outstream_q <= w_char;
            infodump_q  <= w_info;
            sof_q       <= w_sof;
            eop_q       <= w_eop;
            frame_err_q <= w_frame_err;
            sync_err_q  <= w_sync_err;
            chk_err_q   <= w_chk_err;
            busy_q      <= w_busy;
        end
    end

    assign bus.outstream = outstream_q;
    assign bus.infodump  = infodump_q;
    assign bus.sof       = sof_q;
    assign bus.eop       = eop_q;
    assign bus.frame_err = frame_err_q;
    assign bus.sync_err  = sync_err_q;
    assign bus.chk_err   = chk_err_q;
    assign bus.busy      = busy_q;

endmodule

`default_nettype wire
